rr_mux_arbiter: RTL and testbench

// Round-robin arbiter sharing the 4:1 bit multiplexer between four requesters.

---
 rtl/rr_mux_arbiter_if.sv | 21 ++
 rtl/rr_mux_arbiter.sv | 90 +++++++++
 tb/tb_rr_mux_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - request/data/grant bundle between requesters and the round-robin mux arbiter
interface rr_mux_arbiter_if;
  logic [3:0] req;
  logic [3:0] last;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       dout;
  logic       timeout;

  modport master (
    output req, last, din,
    input  gnt, sel, busy, dout, timeout
  );

  modport slave (
    input  req, last, din,
    output gnt, sel, busy, dout, timeout
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter owning a 4:1 bit mux, with hold-timer forced release
module rr_mux_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_mux_arbiter_if.slave   bus
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [CW-1:0] hold_cnt;
  logic [3:0]    gnt_q;
  logic [1:0]    sel_q;
  logic          busy_q;
  logic          dout_q;
  logic          timeout_q;

  logic [1:0]    nxt;
  logic          drop;
  logic          fin;
  logic          hit_max;
  logic          rel;

  // Lowest rotational offset from ptr wins, so the loop runs from the far end back to ptr.
  always_comb begin
    logic [1:0] k;
    nxt = ptr;
    for (int i = 3; i >= 0; i--) begin
      k = ptr + 2'(i);
      if (bus.req[k]) nxt = k;
    end
  end

  assign drop    = ~bus.req[sel_q];
  assign fin     = bus.last[sel_q];
  assign hit_max = (hold_cnt == CW'(MAX_HOLD - 1));
  assign rel     = drop | fin | hit_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= '0;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      busy_q    <= 1'b0;
      dout_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            gnt_q    <= 4'b0001 << nxt;
            sel_q    <= nxt;
            busy_q   <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            gnt_q     <= 4'b0000;
            busy_q    <= 1'b0;
            dout_q    <= 1'b0;
            ptr       <= sel_q + 2'd1;
            state     <= IDLE;
            timeout_q <= hit_max & ~drop & ~fin;
          end else begin
            dout_q   <= bus.din[sel_q];
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.dout    = dout_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

  localparam int MAX_HOLD = 16;

  logic clk;
  logic rst_n;
  rr_mux_arbiter_if bus ();

  rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state; expected outputs are packed {gnt,sel,busy,dout,timeout}.
  logic        m_grant;
  logic [1:0]  m_ptr;
  int          m_cnt;
  logic [3:0]  m_gnt;
  logic [1:0]  m_sel;
  logic        m_busy, m_dout, m_to;
  logic [8:0]  exp_q[$];

  task automatic model_reset();
    m_grant = 1'b0; m_ptr = 2'd0; m_cnt = 0;
    m_gnt = 4'b0; m_sel = 2'd0; m_busy = 1'b0; m_dout = 1'b0; m_to = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic [3:0] d);
    bit a, b, c, found;
    int idx;
    m_to = 1'b0;
    if (!m_grant) begin
      found = 0;
      for (int j = 0; j < 4; j++) begin
        idx = (int'(m_ptr) + j) % 4;
        if (!found && r[idx]) begin
          found   = 1;
          m_sel   = 2'(idx);
          m_gnt   = 4'(1 << idx);
          m_busy  = 1'b1;
          m_cnt   = 0;
          m_grant = 1'b1;
        end
      end
    end else begin
      a = !r[m_sel];
      b = l[m_sel];
      c = (m_cnt == MAX_HOLD - 1);
      if (a || b || c) begin
        m_gnt   = 4'b0;
        m_busy  = 1'b0;
        m_dout  = 1'b0;
        m_ptr   = m_sel + 2'd1;
        m_grant = 1'b0;
        m_to    = c && !a && !b;
      end else begin
        m_dout = d[m_sel];
        m_cnt++;
      end
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic [3:0] d);
    logic [8:0] e;
    bus.req = r; bus.last = l; bus.din = d;
    model_step(r, l, d);
    exp_q.push_back({m_gnt, m_sel, m_busy, m_dout, m_to});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("sb", {23'd0, bus.gnt, bus.sel, bus.busy, bus.dout, bus.timeout}, {23'd0, e});
  endtask

  task automatic do_reset();
    bus.req = 4'b0; bus.last = 4'b0; bus.din = 4'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int   order_exp[5] = '{0, 1, 2, 3, 0};
  int   held;
  logic saw_to;

  initial begin
    bus.req = 4'b0; bus.last = 4'b0; bus.din = 4'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("rst_gnt",  {28'd0, bus.gnt}, 32'h0);
    chk("rst_sel",  {30'd0, bus.sel}, 32'h0);
    chk("rst_busy", {31'd0, bus.busy}, 32'h0);
    chk("rst_dout", {31'd0, bus.dout}, 32'h0);
    chk("rst_to",   {31'd0, bus.timeout}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requester, data bit high, last on the 4th cycle.
    cyc(4'b0100, 4'b0000, 4'b0100);
    chk("t2_gnt", {28'd0, bus.gnt}, 32'h4);
    chk("t2_sel", {30'd0, bus.sel}, 32'h2);
    cyc(4'b0100, 4'b0000, 4'b0100);
    chk("t2_dout", {31'd0, bus.dout}, 32'h1);
    cyc(4'b0100, 4'b0000, 4'b0100);
    cyc(4'b0100, 4'b0100, 4'b0100);
    chk("t2_rel", {28'd0, bus.gnt}, 32'h0);
    cyc(4'b0000, 4'b0000, 4'b0000);

    // Drive ptr to 2 via a grant to requester 1, then check wrap-around scan.
    cyc(4'b0010, 4'b0010, 4'b0000);
    cyc(4'b0010, 4'b0010, 4'b0000);
    cyc(4'b0011, 4'b0000, 4'b0000);
    chk("t5_wrap", {28'd0, bus.gnt}, 32'h1);
    cyc(4'b0011, 4'b0001, 4'b0000);
    cyc(4'b0011, 4'b0000, 4'b0000);
    chk("t5_next", {28'd0, bus.gnt}, 32'h2);
    cyc(4'b0011, 4'b0010, 4'b0000);

    // Asynchronous reset mid-grant.
    cyc(4'b0010, 4'b0000, 4'b0010);
    cyc(4'b0010, 4'b0000, 4'b0010);
    chk("t1_pre_dout", {31'd0, bus.dout}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_gnt",  {28'd0, bus.gnt}, 32'h0);
    chk("t1_busy", {31'd0, bus.busy}, 32'h0);
    chk("t1_dout", {31'd0, bus.dout}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0100, 4'b0000, 4'b0000);
    chk("t1_regrant", {28'd0, bus.gnt}, 32'h4);
    cyc(4'b0100, 4'b0100, 4'b0000);

    // Full contention: round-robin order with one dead cycle between grants.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 4'b0000, 4'($urandom_range(0, 15)));
      chk("t3_order", {28'd0, bus.gnt}, 32'(1 << order_exp[i]));
      cyc(4'b1111, 4'b0000, 4'($urandom_range(0, 15)));
      cyc(4'b1111, 4'b1111, 4'($urandom_range(0, 15)));
      chk("t3_dead", {28'd0, bus.gnt}, 32'h0);
    end

    // Hold timer: requester 1 never finishes, requester 3 waits.
    do_reset();
    cyc(4'b1010, 4'b0000, 4'b0000);
    held = 1;
    saw_to = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(4'b1010, 4'b0000, 4'b0000);
      if (bus.gnt == 4'b0010) held++;
      else begin
        saw_to = bus.timeout;
        break;
      end
    end
    chk("t4_len", 32'(held), 32'(MAX_HOLD));
    chk("t4_to", {31'd0, saw_to}, 32'h1);
    cyc(4'b1010, 4'b0000, 4'b0000);
    chk("t4_to_pulse", {31'd0, bus.timeout}, 32'h0);
    cyc(4'b1010, 4'b0000, 4'b0000);
    chk("t4_next", {28'd0, bus.gnt}, 32'h8);

    // Granted requester drops while req[0] rises.
    cyc(4'b0001, 4'b0000, 4'b0000);
    chk("t6_rel", {28'd0, bus.gnt}, 32'h0);
    chk("t6_to", {31'd0, bus.timeout}, 32'h0);
    cyc(4'b0001, 4'b0000, 4'b0000);
    chk("t6_gnt", {28'd0, bus.gnt}, 32'h1);
    // Drop and last together on requester 0.
    cyc(4'b0000, 4'b0001, 4'b0000);
    chk("t6b_to", {31'd0, bus.timeout}, 32'h0);
    chk("t6b_gnt", {28'd0, bus.gnt}, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(4'($urandom_range(0, 15)),
          ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
          4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 60; i++) begin
      cyc(4'b1111, 4'b0000, 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
